// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128 key expansion.
// Captures a 128-bit cipher key on an accepted start. It then generates round
// keys 1..10, one per clock, and holds all 11 round keys in a register file.
// The keys are read back through an indexed port with registered read data.
//
// Optional feature macro: AES_KSCHED_STREAM_EN adds a registered streaming
// port that presents each key on the cycle after it is written.
//
// Ports:
//   clk       in   1    clock, rising edge
//   rst       in   1    synchronous active-high reset
//   start     in   1    one-cycle request to expand key_in (ignored while busy)
//   key_in    in   128  cipher key, word 0 in [127:96]
//   busy      out  1    rounds 1..10 in progress
//   done      out  1    all 11 keys valid; held until next accepted start/rst
//   rd_idx    in   4    round-key read index 0..10 (11..15 read as zero)
//   rd_key    out  128  registered read data
//   rk_valid  out  1    (stream only) pulse per key written
//   rk_idx    out  4    (stream only) index of streamed key
//   rk_out    out  128  (stream only) streamed key value
module aes_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`ifdef AES_KSCHED_STREAM_EN
  ,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_out
`endif
);

  localparam int unsigned NUM_KEYS   = 11;
  localparam int unsigned LAST_ROUND = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state;
  logic [127:0] key_mem [NUM_KEYS];
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [127:0] prev_key;

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // xtime: multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box: multiplicative inverse as x^254 (0 maps to 0) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  // Round-key generation from the previous key and the round constant.
  logic [127:0] last_round_key;
  logic [31:0]  rcon_col;
  logic [127:0] round_key;

  assign last_round_key = prev_key;
  assign rcon_col       = {rcon, 24'h0};

  always_comb begin
    logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;
    w0  = last_round_key[127:96];
    w1  = last_round_key[95:64];
    w2  = last_round_key[63:32];
    w3  = last_round_key[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = w0 ^ sub ^ rcon_col;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    round_key = {n0, n1, n2, n3};
  end

  // Control, key storage and read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      round    <= 4'd0;
      rcon     <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      prev_key <= 128'h0;
      rd_key   <= 128'h0;
      for (int i = 0; i < NUM_KEYS; i++) key_mem[i] <= 128'h0;
`ifdef AES_KSCHED_STREAM_EN
      rk_valid <= 1'b0;
      rk_idx   <= 4'd0;
      rk_out   <= 128'h0;
`endif
    end else begin
      // Old contents are returned when the same entry is written this edge.
      if (rd_idx < 4'(NUM_KEYS)) rd_key <= key_mem[rd_idx];
      else                       rd_key <= 128'h0;
`ifdef AES_KSCHED_STREAM_EN
      rk_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            key_mem[0] <= key_in;
            prev_key   <= key_in;
            round      <= 4'd1;
            rcon       <= 8'h01;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= RUN;
`ifdef AES_KSCHED_STREAM_EN
            rk_valid   <= 1'b1;
            rk_idx     <= 4'd0;
            rk_out     <= key_in;
`endif
          end
        end
        RUN: begin
          // start is deliberately not examined here.
          key_mem[round] <= round_key;
          prev_key       <= round_key;
          round          <= round + 4'd1;
          rcon           <= xtime(rcon);
`ifdef AES_KSCHED_STREAM_EN
          rk_valid       <= 1'b1;
          rk_idx         <= round;
          rk_out         <= round_key;
`endif
          if (round == 4'(LAST_ROUND)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: randomized self-checking bench for aes_key_schedule.
// The reference expands keys word by word (FIPS-197 style) using an S-box
// table built from the log/antilog generator walk.
module tb_aes_key_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`ifdef AES_KSCHED_STREAM_EN
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`endif

  aes_key_schedule dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key_in (key_in),
    .busy   (busy),
    .done   (done),
    .rd_idx (rd_idx),
    .rd_key (rd_key)
`ifdef AES_KSCHED_STREAM_EN
    ,
    .rk_valid (rk_valid),
    .rk_idx   (rk_idx),
    .rk_out   (rk_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_keys [11];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box via the generator-3 walk; independent of the inverse computation.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // Standard 44-word AES-128 expansion into exp_keys.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) exp_keys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Start an expansion and check busy/done (and stream) on every cycle up to
  // E+10. Optionally pulse a competing start at RUN cycle pulse_at.
  task automatic run_expansion(input logic [127:0] key, input int pulse_at,
                               input logic [127:0] pulse_key);
    start  = 1'b1;
    key_in = key;
    tick();
    start  = 1'b0;
    key_in = rand_key();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        if (k == pulse_at) begin
          start  = 1'b1;
          key_in = pulse_key;
        end
        tick();
        start = 1'b0;
      end
      check($sformatf("busy@E+%0d", k), 128'(busy), (k < 10) ? 128'd1 : 128'd0);
      check($sformatf("done@E+%0d", k), 128'(done), (k < 10) ? 128'd0 : 128'd1);
`ifdef AES_KSCHED_STREAM_EN
      check($sformatf("rk_valid@E+%0d", k), 128'(rk_valid), 128'd1);
      check($sformatf("rk_idx@E+%0d", k), 128'(rk_idx), 128'(k));
      check($sformatf("rk_out@E+%0d", k), rk_out, exp_keys[k]);
`endif
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      check($sformatf("rd_key[%0d]", i), rd_key, (i < 11) ? exp_keys[i] : 128'h0);
    end
  endtask

  initial begin
    logic [127:0] ka, kb;
    build_sbox();
    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;
    rd_idx = 4'd0;
    tick();
    tick();
    check("reset busy", 128'(busy), 128'd0);
    check("reset done", 128'(done), 128'd0);
    check("reset rd_key", rd_key, 128'h0);
    rst = 1'b0;
    tick();

    // FIPS-197 appendix key.
    ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand(ka);
    check("model key1", exp_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    run_expansion(ka, -1, '0);
    rd_idx = 4'd1;
    tick();
    check("fips key1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_idx = 4'd2;
    tick();
    check("fips key2", rd_key, 128'hf2c295f27a96b9435935807a7359f67f);
    rd_idx = 4'd10;
    tick();
    check("fips key10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_all();

    // Competing start mid-RUN must be ignored.
    ka = rand_key();
    kb = rand_key();
    expand(ka);
    run_expansion(ka, 4, kb);
    read_all();

    // Reset during RUN, with a simultaneous start that must be ignored.
    ka = rand_key();
    start  = 1'b1;
    key_in = ka;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst    = 1'b1;
    start  = 1'b1;
    key_in = rand_key();
    rd_idx = 4'd3;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst busy", 128'(busy), 128'd0);
    check("rst done", 128'(done), 128'd0);
    check("rst rd_key", rd_key, 128'h0);
    tick();
    check("post-rst busy", 128'(busy), 128'd0);
    check("post-rst mem", rd_key, 128'h0);

    // Fresh start; read key1 on its write edge returns the old (zero) value.
    ka = rand_key();
    expand(ka);
    rd_idx = 4'd1;
    start  = 1'b1;
    key_in = ka;
    tick();
    start = 1'b0;
    check("fresh busy", 128'(busy), 128'd1);
    tick();
    check("same-edge read old", rd_key, 128'h0);
    tick();
    check("same-edge read new", rd_key, exp_keys[1]);
    for (int i = 3; i <= 10; i++) tick();
    check("fresh done", 128'(done), 128'd1);
    check("fresh busy low", 128'(busy), 128'd0);
    read_all();

    // Restart after done with the FIPS appendix C.1 key.
    ka = 128'h000102030405060708090a0b0c0d0e0f;
    expand(ka);
    run_expansion(ka, -1, '0);
    rd_idx = 4'd10;
    tick();
    check("c1 key10", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Back-to-back: start in the cycle right after done rises.
    ka = rand_key();
    expand(ka);
    run_expansion(ka, -1, '0);
    kb = rand_key();
    expand(kb);
    run_expansion(kb, -1, '0);
    read_all();

    // Randomized keys.
    for (int r = 0; r < 4; r++) begin
      ka = rand_key();
      expand(ka);
      run_expansion(ka, -1, '0);
      read_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential AES-128 key expansion controller. It captures a 128-bit cipher key, iterates the team's combinational `generateRoundKey` module once per clock to produce round keys 1..10, and holds all 11 round keys in an internal register file. The cipher round datapath reads the keys through an indexed, registered read port. The block sits directly upstream of the cipher rounds and drives `generateRoundKey`'s `lastRoundKey` and `rcon_col` inputs.

## Interface
Parameters:
- none; fixed at AES-128 (10 rounds, 11 round keys).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; requests expansion of `key_in`.
- `key_in`  in  128  cipher key, word 0 in bits [127:96]; sampled only on an accepted `start`.
- `busy`  out  1  high while rounds 1..10 are being generated.
- `done`  out  1  high once all 11 keys are valid; held until the next accepted `start` or `rst`.
- `rd_idx`  in  4  round-key index, 0..10.
- `rd_key`  out  128  registered read data for `rd_idx`.
- `rk_valid`, `rk_idx[3:0]`, `rk_out[127:0]`  out  streaming port; present only with `AES_KSCHED_STREAM_EN`.

## Operation
- Internal state:
  - `key_mem[0:10]` (128b each)
  - `round` (4b)
  - `rcon` (8b)
  - `busy` and `done` flags
- `rcon_col` = {`rcon`, 24'h0}.
- `lastRoundKey` = `key_mem[round-1]`, held in a dedicated `prev_key` register so that no memory read mux sits in the key path.
- States:
  - IDLE (`busy`=0).
  - RUN (`busy`=1).
  - The DONE condition is the `done` flag set while in IDLE.
- IDLE + `start`:
  - `key_mem[0]`←`key_in`, `prev_key`←`key_in`
  - `round`←1, `rcon`←8'h01
  - `busy`←1, `done`←0
  - Go to RUN.
- RUN, each cycle:
  - `key_mem[round]`←`roundKey`, `prev_key`←`roundKey`
  - `round`←`round`+1
  - `rcon`←xtime(`rcon`): if bit 7 is set, (`rcon`<<1)^8'h1b, else `rcon`<<1.
- `rcon` sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- RUN with `round`==10: write key 10, then `busy`←0, `done`←1, go to IDLE.
- `start` during RUN: ignored. The expansion is neither restarted nor corrupted.
- `start` while `done`=1: accepted, full restart, `done` drops on the accepting edge.
- Read port:
  - `rd_key`←`key_mem[rd_idx]` every cycle.
  - `rd_idx` of 11..15 → `rd_key`←128'h0.
  - Reads during RUN return the current contents, which may be stale. Consumers must wait for `done`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `rd_key`=0.
  - `round`=0, `rcon`=0.
  - All `key_mem` entries = 0.
  - `rk_valid`=0, `rk_idx`=0, `rk_out`=0.
- Expansion latency: with `start` sampled at edge E, key k is written at edge E+k (k=0..10). `busy` is high from after E until after E+10. `done` is visible after E+10, i.e. 10 cycles after the accepting edge.
- Read latency: 1 cycle from `rd_idx` to `rd_key`.
- Same-cycle read of a key written on the same edge returns the old value; the new value appears one cycle later.
- `rst` asserted mid-RUN: on that edge all state returns to reset values and the expansion is abandoned. `start` in the same cycle as `rst` is ignored.
- Back-to-back use: `start` in the cycle after `done` rises is accepted.

## Configuration
- `AES_KSCHED_STREAM_EN` defined:
  - Adds `rk_valid`, `rk_idx` and `rk_out`, all registered.
  - `rk_valid` pulses for one cycle alongside each `key_mem` write, 11 pulses per expansion (indices 0..10). This lets a pipelined cipher consume keys without using the read port.
- `AES_KSCHED_STREAM_EN` undefined:
  - The three ports and their registers do not exist.
  - All other behaviour is identical.

## Test plan
- Reset, then `start` with `key_in`=2b7e151628aed2a6abf7158809cf4f3c → `busy` high for 10 cycles, then `done`=1; `rd_idx`=1 returns a0fafe1788542cb123a339392a6c7605 one cycle later.
- Same run, read all indices → idx0=2b7e1516…09cf4f3c, idx2=f2c295f27a96b9435935807a7359f67f, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6; idx 11..15 return 0.
- Pulse `start` with a different key at cycle 4 of RUN → ignored; final keys match the first key's expansion and `done` timing is unchanged.
- Assert `rst` at cycle 5 of RUN → `busy`=0, `done`=0, `rd_key`=0 next cycle; a fresh `start` then yields correct keys.
- After `done`, `start` with key 000102030405060708090a0b0c0d0e0f → `done` drops, returns after 10 cycles; `rd_idx`=10 returns 13111d7fe3944a17f307a78b4d2b30c5.
- With `AES_KSCHED_STREAM_EN`: `rk_valid` pulses on 11 consecutive cycles with `rk_idx` 0..10 and `rk_out` matching `key_mem`; check internal `rcon` sequence 01..36 including the 80→1b wrap.
